// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter:
// default widths, FSM state encoding, requester id type and the
// statistics counter width with its saturating increment.
package dmem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

  typedef logic req_id_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake and memory-port bundle for dmem_arbiter.
// slave  : the arbiter side (drives ready, responses and the memory port).
// master : the requester/memory side.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_in_data;
  logic [DW-1:0] mem_out_data;

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  mem_out_data,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_in_data
  );

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output mem_out_data,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_in_data
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way grant: a lone requester always wins; on a tie the
// requester that was not served last wins, or requester 0 when fixed
// priority is selected. Output is one-hot (or zero when nobody requests).
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_grant_i,
  input  logic       fixed_prio_i,
  output logic [1:0] gnt_o
);

  // Grant decode from the request pattern and the tie-break policy.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (fixed_prio_i || last_grant_i) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous single-port data memory between two requesters.
// Each access runs IDLE -> ISSUE -> CAPTURE -> IDLE: the command is held on
// the memory port for one cycle, the same address is then read back with
// we=0, and the readback is returned as a one-cycle response pulse.
// Writes return the written data as an acknowledge.
// Optional: define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_grant0,
  output logic [STAT_W-1:0]  stat_grant1,
  output logic [STAT_W-1:0]  stat_conflict
`endif
);

  state_t        state_q, state_d;
  req_id_t       owner_q, owner_d;
  req_id_t       last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rsp_q, rsp_d;
  logic [1:0]    gnt;
  logic [1:0]    hs;

  rr_arb2 u_arb (
    .req_i        (bus.req_valid),
    .last_grant_i (last_q),
    .fixed_prio_i (FIXED_PRIO != 0),
    .gnt_o        (gnt)
  );

  // Ready only for the winner and only while no transaction is in flight.
  assign bus.req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign hs            = bus.req_valid & bus.req_ready;

  assign bus.mem_addr    = addr_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_in_data = wdata_q;
  assign bus.rsp_valid   = rsp_q;
  assign bus.rsp_rdata   = rdata_q;

  // Next-state and memory-port sequencing for one access at a time.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rsp_d   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (hs != 2'b00) begin
          owner_d = hs[1];
          addr_d  = hs[1] ? bus.req_addr1 : bus.req_addr0;
          wdata_d = hs[1] ? bus.req_wdata1 : bus.req_wdata0;
          we_d    = bus.req_we[hs[1]];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Memory executes the command at this edge; next cycle re-reads.
        we_d    = 1'b0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rdata_d         = bus.mem_out_data;
        rsp_d[owner_q]  = 1'b1;
        last_d          = owner_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and memory-port registers; reset drops mem_we at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] g0_q, g1_q, cf_q;

  // Saturating counters of handshakes per requester and contended IDLE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g0_q <= '0;
      g1_q <= '0;
      cf_q <= '0;
    end else begin
      if (hs[0]) g0_q <= sat_inc(g0_q);
      if (hs[1]) g1_q <= sat_inc(g1_q);
      if ((state_q == IDLE) && (&bus.req_valid)) cf_q <= sat_inc(cf_q);
    end
  end

  assign stat_grant0   = g0_q;
  assign stat_grant1   = g1_q;
  assign stat_conflict = cf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level reference model; a second instance
// with fixed priority is exercised by a directed scenario.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();
  dmem_arbiter_if #(.AW(8), .DW(8)) bus_fp ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] sg0, sg1, scf, fsg0, fsg1, fscf;
`endif

  dmem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef DMEM_ARB_STATS_EN
    , .stat_grant0(sg0), .stat_grant1(sg1), .stat_conflict(scf)
`endif
  );

  dmem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp)
`ifdef DMEM_ARB_STATS_EN
    , .stat_grant0(fsg0), .stat_grant1(fsg1), .stat_conflict(fscf)
`endif
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 8'h10) return 8'hA5;
    if (i == 8'h05) return 8'h11;
    return 8'((i * 7) + 3);
  endfunction

  // Memories: synchronous, address registered every edge, written when we=1.
  logic [7:0] mem [256];
  logic [7:0] raddr;
  bit         loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_in_data;
    end
    raddr <= bus.mem_addr;
  end
  assign bus.mem_out_data = mem[raddr];

  logic [7:0] mem_fp [256];
  logic [7:0] raddr_fp;
  bit         loaded_fp;
  always @(posedge clk) begin
    if (!loaded_fp) begin
      for (int i = 0; i < 256; i++) mem_fp[i] <= init_val(i);
      loaded_fp <= 1'b1;
    end else if (bus_fp.mem_we) begin
      mem_fp[bus_fp.mem_addr] <= bus_fp.mem_in_data;
    end
    raddr_fp <= bus_fp.mem_addr;
  end
  assign bus_fp.mem_out_data = mem_fp[raddr_fp];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, response three cycles after
  // the handshake, data taken from a shadow memory updated when writes land.
  function automatic logic [1:0] winner(input logic [1:0] v, input bit last);
    if (v == 2'b01 || v == 2'b10) return v;
    if (v == 2'b11) return 2'b01 << (1 - int'(last));
    return 2'b00;
  endfunction

  logic [7:0] ref_mem [256];
  int         age;
  bit         m_owner, m_last, m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic [1:0] m_rsp;
  int         m_g0, m_g1, m_cf;

  task automatic m_reset();
    age = 0; m_owner = 0; m_last = 1; m_we = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_rsp = 0;
    m_g0 = 0; m_g1 = 0; m_cf = 0;
  endtask

  initial begin
    logic [1:0] exp_ready, hs;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      exp_ready = (age == 0) ? winner(bus.req_valid, m_last) : 2'b00;
      check("req_ready", bus.req_ready, exp_ready);
      check("ready never both", &bus.req_ready, 0);
      check("rsp_valid", bus.rsp_valid, m_rsp);
      check("rsp_rdata", bus.rsp_rdata, m_rdata);
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_we", bus.mem_we, (age == 1) ? m_we : 1'b0);
      check("mem_in_data", bus.mem_in_data, m_wdata);
`ifdef DMEM_ARB_STATS_EN
      check("stat_grant0", sg0, m_g0);
      check("stat_grant1", sg1, m_g1);
      check("stat_conflict", scf, m_cf);
`endif
      if (!rst) begin
        m_rsp = 2'b00;
        hs = bus.req_valid & exp_ready;
        if (age == 0 && bus.req_valid == 2'b11 && m_cf < 65535) m_cf++;
        if (age == 2) begin
          m_rdata = ref_mem[m_addr];
          m_rsp[m_owner] = 1'b1;
          m_last = m_owner;
          age = 0;
        end else if (age == 1) begin
          if (m_we) ref_mem[m_addr] = m_wdata;
          age = 2;
        end else if (hs != 2'b00) begin
          m_owner = hs[1];
          m_addr  = hs[1] ? bus.req_addr1 : bus.req_addr0;
          m_wdata = hs[1] ? bus.req_wdata1 : bus.req_wdata0;
          m_we    = bus.req_we[hs[1]];
          if (hs[0] && m_g0 < 65535) m_g0++;
          if (hs[1] && m_g1 < 65535) m_g1++;
          age = 1;
        end
      end
    end
  end

  task automatic set_cmd(input int k, input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.req_valid[k] = 1'b1;
    bus.req_we[k]    = we;
    if (k == 0) begin bus.req_addr0 = a; bus.req_wdata0 = d; end
    else        begin bus.req_addr1 = a; bus.req_wdata1 = d; end
  endtask

  // Called just after a rising edge with valid set; returns just after the
  // handshake edge, or with ok=0 once the budget is spent.
  task automatic wait_hs(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[k]) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    check($sformatf("handshake r%0d", k), ok, 1);
  endtask

  task automatic access(input int k, input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_data);
    bit ok;
    int lat;
    logic [7:0] got;
    @(posedge clk); #1;
    set_cmd(k, we, a, d);
    wait_hs(k, ok);
    bus.req_valid[k] = 1'b0;
    lat = 0; got = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!we) check("read keeps mem_we low", bus.mem_we, 0);
      if (bus.rsp_valid[k]) begin lat = i; got = bus.rsp_rdata; break; end
    end
    check($sformatf("r%0d rsp latency", k), lat, 3);
    check($sformatf("r%0d rsp data @%0h", k, a), got, exp_data);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin #1000000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    bit ok;
    int q_g[$];
    int exp_g [4];
    int n0, n_bad, nrsp, lat;
    logic [1:0] hs;
    exp_g = '{0, 1, 0, 1};
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr0 = 0; bus.req_addr1 = 0;
    bus.req_wdata0 = 0; bus.req_wdata1 = 0;
    bus_fp.req_valid = 0; bus_fp.req_we = 0; bus_fp.req_addr0 = 0; bus_fp.req_addr1 = 0;
    bus_fp.req_wdata0 = 0; bus_fp.req_wdata1 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset mem_in_data", bus.mem_in_data, 0);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset rsp_rdata", bus.rsp_rdata, 0);

    access(0, 1'b0, 8'h10, 8'h00, 8'hA5);
    access(1, 1'b1, 8'h20, 8'h3C, 8'h3C);
    access(0, 1'b0, 8'h20, 8'h00, 8'h3C);

    // Contention after a fresh reset: r0 wins the first tie, then alternates.
    pulse_rst();
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    check("stats clear g0", sg0, 0);
    check("stats clear g1", sg1, 0);
    check("stats clear conflict", scf, 0);
    @(posedge clk); #1;
`endif
    set_cmd(0, 1'b0, 8'h10, 8'h00);
    set_cmd(1, 1'b0, 8'h20, 8'h00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_ready[0]) q_g.push_back(0);
      if (bus.req_ready[1]) q_g.push_back(1);
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    check("rr grant count", q_g.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr grant %0d", i), (i < q_g.size()) ? q_g[i] : 9, exp_g[i]);
    access(0, 1'b0, 8'h20, 8'h00, 8'h3C);
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    check("stat_grant0 literal", sg0, 3);
    check("stat_grant1 literal", sg1, 2);
    check("stat_conflict literal", scf, 4);
`endif

    // Reset during ISSUE of a write: nothing lands, nothing responds.
    @(posedge clk); #1;
    set_cmd(0, 1'b1, 8'h05, 8'hFF);
    wait_hs(0, ok);
    bus.req_valid[0] = 1'b0;
    rst = 1'b1;
    #1 check("mid-reset mem_we", bus.mem_we, 0);
    @(posedge clk); #1; rst = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) nrsp++;
    end
    check("mid-reset no response", nrsp, 0);
    check("mid-reset mem[05] kept", mem[5], 8'h11);
`ifdef DMEM_ARB_STATS_EN
    check("stats after reset", sg0 + sg1 + scf, 0);
`endif
    access(0, 1'b0, 8'h05, 8'h00, 8'h11);

    // Fixed priority instance: r0 always wins while it keeps asking.
    @(posedge clk); #1;
    bus_fp.req_addr0 = 8'h10; bus_fp.req_addr1 = 8'h05;
    bus_fp.req_valid = 2'b11;
    n0 = 0; n_bad = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (bus_fp.req_ready[0]) n0++;
      if (bus_fp.req_ready[1]) n_bad++;
      @(posedge clk); #1;
    end
    bus_fp.req_valid[0] = 1'b0;
    check("fp r0 grants", n0, 3);
    check("fp r1 starved while r0 valid", n_bad, 0);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_fp.req_ready[1]) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("fp r1 granted after r0 drops", ok, 1);
    @(posedge clk); #1;
    bus_fp.req_valid[1] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus_fp.rsp_valid[1]) begin
        lat = i;
        check("fp r1 data", bus_fp.rsp_rdata, 8'h11);
        break;
      end
    end
    check("fp r1 latency", lat, 3);

    // Randomized traffic with holds, cancels and back-to-back requests.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (bus.req_valid[k] && !hs[k]) begin
          if ($urandom_range(15) == 0) bus.req_valid[k] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          set_cmd(k, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
        end else begin
          bus.req_valid[k] = 1'b0;
        end
      end
    end
    bus.req_valid = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
